// File: rtl/uart_pkg.sv
// uart_pkg: FSM states, frame constants and bit-timing helper; UART_TX_PARITY_EN adds the PARITY state
package uart_pkg;
    localparam int DATA_BITS = 8;
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
    function automatic int bit_cycles(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction
endpackage

// File: rtl/baud_tick.sv
// baud_tick: emits a one-cycle tick every CYCLES clocks, restarted by a synchronous clear
module baud_tick #(
    parameter int CYCLES = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int W = $clog2(CYCLES + 1);
    logic [W-1:0] cnt;
    assign tick = cnt == W'(CYCLES - 1);
    // count up to CYCLES-1, wrapping on the tick or when restarted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt <= '0;
        else if (clear || tick) cnt <= '0;
        else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter; UART_TX_PARITY_EN adds an even-parity bit (8E1)
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 9600,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     busy,
    output logic                     tx
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BC = bit_cycles(CLK_HZ, BAUD);
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_n;
    logic [7:0]    shreg;
    logic [2:0]    bit_idx;
    logic          tick, push, pop;
    state_t        state, state_n;
`ifdef UART_TX_PARITY_EN
    logic          par;
`endif
    assign push    = wr_en && !full;
    assign pop     = !empty && (state == IDLE || (state == STOP && tick));
    assign count_n = count + CW'(push) - CW'(pop);
    assign busy    = state != IDLE;
    baud_tick #(.CYCLES(BC)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (pop || state == IDLE),
        .tick  (tick)
    );
    // FIFO pointers, occupancy and registered flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count    <= count_n;
            full     <= count_n == CW'(DEPTH);
            empty    <= count_n == '0;
            overflow <= wr_en && full;
        end
    end
    // FIFO storage needs no reset; only slots behind the pointers are ever read
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end
    // state register, shift register and data-bit counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state <= state_n;
            if (pop) begin
                shreg   <= mem[rd_ptr];
                bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                par     <= ^mem[rd_ptr];
`endif
            end else if (state == DATA && tick) begin
                shreg   <= shreg >> 1;
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end
    // next state and line level
    always_comb begin
        state_n = state;
        tx      = 1'b1;
        case (state)
            IDLE:  if (!empty) state_n = START;
            START: begin
                tx = 1'b0;
                if (tick) state_n = DATA;
            end
            DATA: begin
                tx = shreg[0];
`ifdef UART_TX_PARITY_EN
                if (tick && bit_idx == 3'(DATA_BITS - 1)) state_n = PARITY;
`else
                if (tick && bit_idx == 3'(DATA_BITS - 1)) state_n = STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx = par;
                if (tick) state_n = STOP;
            end
`endif
            STOP:    if (tick) state_n = empty ? IDLE : START;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed table-driven bench for uart_tx_fifo at 10 clocks per bit, DEPTH=4
module tb_uart_tx_fifo;
    localparam int BC = 10;
`ifdef UART_TX_PARITY_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif
    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, overflow, busy, tx;
    logic [2:0] count;
    int         errors = 0;
    int         checks = 0;
    vec_t       vecs [7];
    uart_tx_fifo #(.CLK_HZ(1000), .BAUD(100), .DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .busy     (busy),
        .tx       (tx)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask
    task automatic check_frame(input logic [7:0] d, input logic p, input int start);
        logic [10:0] f;
        int bad [11];
        int bbusy;
        f = FL == 11 ? {1'b1, p, d, 1'b0} : {2'b11, d, 1'b0};
        bbusy = 0;
        for (int b = 0; b < 11; b++) bad[b] = 0;
        for (int k = start; k < FL * BC; k++) begin
            @(negedge clk);
            if (tx !== f[k / BC]) bad[k / BC]++;
            if (busy !== 1'b1) bbusy++;
        end
        for (int b = start / BC; b < FL; b++)
            check($sformatf("tx byte %h bit %0d wrong cycles", d, b), bad[b], 0);
        check($sformatf("busy byte %h low cycles", d), bbusy, 0);
    endtask
    task automatic idle_check();
        @(negedge clk);
        check("idle tx", tx, 1);
        check("idle busy", busy, 0);
        check("idle empty", empty, 1);
    endtask
    initial begin
        int bad;
        vecs[0] = '{8'h41, 1'b0};
        vecs[1] = '{8'h55, 1'b0};
        vecs[2] = '{8'hAA, 1'b0};
        vecs[3] = '{8'h07, 1'b1};
        vecs[4] = '{8'h03, 1'b0};
        vecs[5] = '{8'hFF, 1'b0};
        vecs[6] = '{8'h80, 1'b1};
        @(negedge clk);
        check("reset tx", tx, 1);
        check("reset busy", busy, 0);
        check("reset count", count, 0);
        check("reset empty", empty, 1);
        check("reset full", full, 0);
        check("reset overflow", overflow, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            wr_en = 1'b1;
            wr_data = vecs[i].data;
            @(posedge clk);
            #1 wr_en = 1'b0;
            @(negedge clk);
            check("count after write", count, 1);
            check("busy before start", busy, 0);
            check("tx before start", tx, 1);
            check_frame(vecs[i].data, vecs[i].par, 0);
            idle_check();
        end
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = 8'h55;
        @(negedge clk);
        check("b2b count", count, 1);
        wr_data = 8'hAA;
        @(posedge clk);
        #1 wr_en = 1'b0;
        check_frame(8'h55, 1'b0, 0);
        check_frame(8'hAA, 1'b0, 0);
        idle_check();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            wr_en = 1'b1;
            wr_data = vecs[i].data;
        end
        @(posedge clk);
        #1 wr_en = 1'b0;
        @(negedge clk);
        check("ovf pulse", overflow, 1);
        check("ovf count", count, 4);
        check("ovf full", full, 1);
        @(negedge clk);
        check("ovf pulse end", overflow, 0);
        check("ovf count hold", count, 4);
        check_frame(vecs[0].data, vecs[0].par, 6);
        for (int i = 1; i < 5; i++) check_frame(vecs[i].data, vecs[i].par, 0);
        idle_check();
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = 8'h55;
        @(negedge clk);
        wr_data = 8'hAA;
        @(posedge clk);
        #1 wr_en = 1'b0;
        repeat (36) @(negedge clk);
        check("pre-reset busy", busy, 1);
        check("pre-reset count", count, 1);
        #2 reset = 1'b0;
        #1;
        check("async reset tx", tx, 1);
        check("async reset busy", busy, 0);
        check("async reset count", count, 0);
        check("async reset empty", empty, 1);
        check("async reset full", full, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("post-reset line activity cycles", bad, 0);
        check("post-reset count", count, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLK_HZ, default 100000000: input clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600: serial bit rate.
REQ-003 Parameter DEPTH, default 16: FIFO entries; power of two, 2..256.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 wr_en  input  1  write strobe; one byte is offered per cycle while high.
REQ-007 wr_data  input  8  byte to transmit, sampled when wr_en=1.
REQ-008 full  output  1  FIFO holds DEPTH entries.
REQ-009 empty  output  1  FIFO holds 0 entries.
REQ-010 count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-011 overflow  output  1  one-cycle pulse when a write is rejected.
REQ-012 busy  output  1  high while a frame is on the line.
REQ-013 tx  output  1  serial line, idle high.

Function
REQ-014 BIT_CYCLES = CLK_HZ/BAUD, integer truncation; at the defaults this is 10416.
REQ-015 A write is accepted when wr_en=1 and full=0; the byte is stored at the tail and count increments next cycle.
REQ-016 A write with full=1 is dropped, FIFO is unchanged, and overflow=1 for exactly that cycle+1.
REQ-017 The full flag is registered, so a write while full is rejected even if a pop occurs in the same cycle.
REQ-018 A simultaneous accepted write and pop leave count unchanged.
REQ-019 The FSM has states IDLE, START, DATA, PARITY (REQ-029 only), and STOP.
REQ-020 IDLE with empty=0: pop the head byte into the shift register; the next cycle is START with tx=0 and the bit counter at 0.
REQ-021 Each line bit holds for exactly BIT_CYCLES clocks, timed by the bit-tick counter.
REQ-022 DATA shifts 8 bits LSB first, then STOP drives tx=1 for BIT_CYCLES.
REQ-023 At the end of STOP: if empty=0, pop and enter START with no idle gap; otherwise enter IDLE.
REQ-024 busy=1 in every state except IDLE.
REQ-025 tx=1 in IDLE.
REQ-026 Pointers wrap modulo DEPTH; count saturates at neither end, because REQ-015/016 prevent over- and underflow.

Reset
REQ-027 While reset=0: FSM=IDLE, tx=1, busy=0, count=0, empty=1, full=0, overflow=0, pointers=0, counters=0.
REQ-028 Reset asserted mid-frame aborts the frame immediately, drives tx=1, and discards FIFO contents.

Configuration
REQ-029 With macro UART_TX_PARITY_EN defined, an even-parity bit (XOR of the 8 data bits) is sent in the PARITY state between DATA and STOP, giving an 11-bit frame; without it, PARITY is absent and the frame is 10 bits (8N1).

Structure
REQ-030 Package uart_pkg holds the FSM state enum, the DATA_BITS=8 constant, and the BIT_CYCLES calculation function.
REQ-031 Sub-module baud_tick: a counter that emits a one-cycle tick every BIT_CYCLES clocks and restarts on a sync-clear input; the FIFO storage stays inline.

Verification
REQ-032 Use CLK_HZ=1000 and BAUD=100 (BIT_CYCLES=10). Write 0x41 once -> tx low for 10 cycles, then 1,0,0,0,0,0,1,0 at 10 cycles each, then high for 10; busy high for 100 cycles total.
REQ-033 Write 0x55 and 0xAA on consecutive cycles -> two back-to-back frames, 200 cycles, with no idle cycle between the STOP and the second START.
REQ-034 With DEPTH=4 and the line held busy, write 6 bytes -> first byte popped, next 4 stored, full=1, sixth write gives overflow=1 for one cycle and count=4.
REQ-035 Assert reset at cycle 35 of a frame -> tx=1, busy=0, and count=0 asynchronously; no partial bits follow after release.
REQ-036 UART_TX_PARITY_EN defined, write 0x07 -> parity bit 1 and 110-cycle frame; write 0x03 -> parity bit 0.
